dot_product_scheduler: RTL
==========================

Name: dot_product_scheduler

Overview:
- Sequencer and arbiter for one shared dotProduct_macro. Two requesters each present an operand-vector pair through a valid/ready handshake.
- The block grants one requester round-robin, serializes its operands onto SerialData behind a Start pulse, and waits for Done.
- It captures DataOut and returns the result, tagged with the requester ID, through a valid/ready response port.
- Sits between the system-level vector sources and the dotProduct_macro instance.

Parameters:
- NUM_ELEM, 8, elements per vector.
- ELEM_W, 8, bits per unsigned element.
- RES_W, 19, result width; must equal the macro's DataOut width.
- TIMEOUT, 1023, maximum WAIT cycles for Done before an error response is issued.

Ports:
- clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has an operand pair.
- req0_ready  out  1  requester 0 pair accepted this cycle.
- req0_a  in  NUM_ELEM*ELEM_W  vector A; element i at bits [i*ELEM_W +: ELEM_W].
- req0_b  in  NUM_ELEM*ELEM_W  vector B, same packing.
- req1_valid, req1_ready, req1_a, req1_b: same as requester 0.
- SerialData  out  1  serial operand bit to the macro.
- Start  out  1  one-cycle start pulse to the macro.
- DataOut  in  RES_W  macro result; valid in the Done cycle.
- Done  in  1  macro completion pulse.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  1  requester that owns the response.
- rsp_data  out  RES_W  dot-product result; 0 on error.
- rsp_err  out  1  response was produced by timeout.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (Reset=0, asynchronous): state=IDLE, rr_ptr=0, all counters 0. SerialData, Start, req*_ready, rsp_valid, rsp_id, rsp_data, rsp_err and busy all drive 0. Reset asserted in any state, including mid-SHIFT, aborts the transaction; nothing is replayed.
- Transaction states, in order:
  - IDLE: if only one reqN_valid is high, grant it. If both are high, grant the requester equal to rr_ptr. reqN_ready is combinational (state==IDLE && grant==N) and is asserted in that same cycle; the operands are latched on that edge. Next state is START.
  - START: Start=1 for exactly one cycle, SerialData=0. Next state is SHIFT.
  - SHIFT: 2*NUM_ELEM*ELEM_W cycles (128 at defaults), one bit per cycle. Element order is A0,B0,A1,B1,...,A(N-1),B(N-1); each element is sent MSB first. Start=0. After the last bit, next state is WAIT.
  - WAIT: SerialData=0. On Done=1, capture DataOut into rsp_data, set rsp_err=0, go to RESP. If the wait counter reaches TIMEOUT cycles without Done, set rsp_data=0, rsp_err=1, go to RESP.
  - RESP: rsp_valid=1 with rsp_id=granted requester; rsp_valid, rsp_id, rsp_data and rsp_err stay stable until rsp_ready=1. On the acceptance edge: rsp_valid goes to 0, rr_ptr becomes the inverse of the served ID, next state is IDLE.
- Throughput and latency:
  - Request acceptance to first SHIFT bit: 2 cycles.
  - Done to rsp_valid: 1 cycle.
  - A new request can be granted in the cycle after response acceptance.
- Requests arriving while busy: ready stays low; the requester must hold valid and its data stable.
- Done outside WAIT (IDLE, START, SHIFT, RESP) is ignored. Done arriving in the same cycle as the timeout terminal count counts as success.
- rr_ptr changes only on response acceptance, never on a timeout alone, so fairness is: after serving N, the other requester wins any tie.
- Arithmetic: the block never computes the product. rsp_data is a verbatim copy of DataOut, with no truncation.

Test Plan:
- Single request on req0 with A=1..8, B all 1, macro model returns 36. Check: req0_ready high for exactly 1 cycle, Start pulses once, SerialData streams 00000001,00000001,00000010,... for 128 cycles, rsp_valid with rsp_id=0 and rsp_data=36.
- Both valid in the same cycle, reset state. Check: req0 served first, then req1. Repeat with both still valid: req0 again, confirming alternation 0,1,0,1.
- Backpressure: hold rsp_ready=0 for 20 cycles after rsp_valid. Check: rsp_data, rsp_id and rsp_err stable throughout, no new grant, req1_ready stays 0 until acceptance.
- Timeout: macro model never asserts Done. Check: rsp_valid after exactly TIMEOUT WAIT cycles with rsp_err=1 and rsp_data=0. Then a spurious Done while IDLE produces no response.
- Reset pulse at SHIFT bit 40. Check: all outputs 0 immediately and asynchronously. After release, a new req1 transaction completes correctly with A=B=all 255, returning 520200.
- Done injected during SHIFT. Check: it is ignored, the full 128 bits are still sent, and the response is taken from the Done that arrives in WAIT.

Source files
------------

// File: rtl/dot_product_scheduler_if.sv
// Bundle of the two requester ports, the macro link and the response port
// around the shared dot-product macro.
interface dot_product_scheduler_if #(
  parameter int NUM_ELEM = 8,
  parameter int ELEM_W   = 8,
  parameter int RES_W    = 19
);
  logic                         req0_valid;
  logic                         req0_ready;
  logic [NUM_ELEM*ELEM_W-1:0]   req0_a;
  logic [NUM_ELEM*ELEM_W-1:0]   req0_b;
  logic                         req1_valid;
  logic                         req1_ready;
  logic [NUM_ELEM*ELEM_W-1:0]   req1_a;
  logic [NUM_ELEM*ELEM_W-1:0]   req1_b;
  logic                         SerialData;
  logic                         Start;
  logic [RES_W-1:0]             DataOut;
  logic                         Done;
  logic                         rsp_valid;
  logic                         rsp_ready;
  logic                         rsp_id;
  logic [RES_W-1:0]             rsp_data;
  logic                         rsp_err;
  logic                         busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    input  DataOut, Done, rsp_ready,
    output req0_ready, req1_ready, SerialData, Start,
    output rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    output DataOut, Done, rsp_ready,
    input  req0_ready, req1_ready, SerialData, Start,
    input  rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/dot_product_scheduler.sv
// Round-robin arbiter and bit-serial sequencer for one shared dotProduct_macro;
// returns the macro result tagged with the requester ID.
module dot_product_scheduler #(
  parameter int NUM_ELEM = 8,
  parameter int ELEM_W   = 8,
  parameter int RES_W    = 19,
  parameter int TIMEOUT  = 1023
) (
  input  logic                     clk,
  input  logic                     Reset,
  dot_product_scheduler_if.slave   bus
);

  localparam int VEC_W   = NUM_ELEM * ELEM_W;
  localparam int SER_W   = 2 * VEC_W;
  localparam int BIT_CW  = (SER_W > 1) ? $clog2(SER_W) : 1;
  localparam int WAIT_CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [BIT_CW-1:0]  BIT_LAST  = BIT_CW'(SER_W - 1);
  localparam logic [WAIT_CW-1:0] WAIT_LAST = WAIT_CW'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  logic [2:0]         state;
  logic               rr_ptr;
  logic               gnt_id;
  logic [BIT_CW-1:0]  bit_cnt;
  logic [WAIT_CW-1:0] wait_cnt;
  logic [RES_W-1:0]   rsp_data_q;
  logic               rsp_err_q;
  logic [SER_W-1:0]   ser_q;
  logic               grant;
  logic               accept;

  // Lay the operands out in transmit order: A0,B0,A1,B1,... each MSB first,
  // so the serial bit is always the top of the shift register.
  function automatic logic [SER_W-1:0] pack_operands(input logic [VEC_W-1:0] a,
                                                     input logic [VEC_W-1:0] b);
    logic [SER_W-1:0] s;
    s = '0;
    for (int i = 0; i < NUM_ELEM; i++) begin
      s[SER_W-1-(2*i)*ELEM_W   -: ELEM_W] = a[i*ELEM_W +: ELEM_W];
      s[SER_W-1-(2*i+1)*ELEM_W -: ELEM_W] = b[i*ELEM_W +: ELEM_W];
    end
    return s;
  endfunction

  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) grant = rr_ptr;
    else if (bus.req1_valid)               grant = 1'b1;
  end

  // Ready is qualified by Reset so it stays low while reset is held.
  assign bus.req0_ready = Reset && (state == S_IDLE) && bus.req0_valid && !grant;
  assign bus.req1_ready = Reset && (state == S_IDLE) && bus.req1_valid &&  grant;
  assign accept         = bus.req0_ready || bus.req1_ready;

  assign bus.Start      = (state == S_START);
  assign bus.SerialData = (state == S_SHIFT) ? ser_q[SER_W-1] : 1'b0;
  assign bus.busy       = (state != S_IDLE);
  assign bus.rsp_valid  = (state == S_RESP);
  assign bus.rsp_id     = gnt_id;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_err    = rsp_err_q;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state      <= S_IDLE;
      rr_ptr     <= 1'b0;
      gnt_id     <= 1'b0;
      bit_cnt    <= '0;
      wait_cnt   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            gnt_id <= grant;
            state  <= S_START;
          end
        end
        S_START: begin
          bit_cnt <= '0;
          state   <= S_SHIFT;
        end
        S_SHIFT: begin
          if (bit_cnt == BIT_LAST) begin
            wait_cnt <= '0;
            state    <= S_WAIT;
          end else begin
            bit_cnt <= bit_cnt + BIT_CW'(1);
          end
        end
        S_WAIT: begin
          // Done wins over a timeout landing in the same cycle.
          if (bus.Done) begin
            rsp_data_q <= bus.DataOut;
            rsp_err_q  <= 1'b0;
            state      <= S_RESP;
          end else if (wait_cnt == WAIT_LAST) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
            state      <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + WAIT_CW'(1);
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rr_ptr <= ~gnt_id;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Operand shift register carries data only, so it is not reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      ser_q <= grant ? pack_operands(bus.req1_a, bus.req1_b)
                     : pack_operands(bus.req0_a, bus.req0_b);
    end else if (state == S_SHIFT) begin
      ser_q <= {ser_q[SER_W-2:0], 1'b0};
    end
  end

endmodule
